pipe_reg_de: RTL

Decode-to-execute pipeline register for the pipelined RISC-V core. It captures the decoded instruction bundle at the end of decode and presents it to execute, where it drives the execute-stage register specifiers, immediate-format select and control fields. It supports holding (stall) and bubble insertion (flush), and tracks a valid bit so squashed slots are distinguishable from real instructions.

---
 rtl/core_pkg.sv | 71 +++++++
 rtl/sat_counter.sv | 32 +++
 rtl/pipe_reg_de.sv | 101 ++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
//   Shared definitions for the pipelined RISC-V core: the decode-to-execute
//   instruction bundle, its all-zero bubble value, and the RegWrite / ImmSrc
//   encodings that the forwarding and hazard logic also decode.
//   Optional feature macro used by pipe_reg_de: DE_BUBBLE_CNT_EN.
// ---------------------------------------------------------------------------
package core_pkg;

    localparam int XLEN   = 32;     // operand / PC / immediate width
    localparam int REG_AW = 5;      // register specifier width

    localparam logic [6:0] OPC_LOAD = 7'd3;

    // RegWrite encoding: zero means "no architectural write", so a bubble
    // can never be picked as a forwarding source.
    localparam logic [2:0] RW_NONE = 3'b000;
    localparam logic [2:0] RW_ALU  = 3'b001;
    localparam logic [2:0] RW_MEM  = 3'b010;
    localparam logic [2:0] RW_PC4  = 3'b011;
    localparam logic [2:0] RW_IMM  = 3'b100;

    // Immediate format select.
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    typedef struct packed {
        logic [XLEN-1:0]   RD1;
        logic [XLEN-1:0]   RD2;
        logic [XLEN-1:0]   PC;
        logic [XLEN-1:0]   PCPlus4;
        logic [XLEN-1:0]   ImmExt;
        logic [REG_AW-1:0] Rs1;
        logic [REG_AW-1:0] Rs2;
        logic [REG_AW-1:0] Rd;
        logic [2:0]        RegWrite;
        logic [2:0]        ImmSrc;
        logic [1:0]        ResultSrc;
        logic [3:0]        ALUControl;
        logic              ALUSrc;
        logic              MemWrite;
        logic              Branch;
        logic              Jump;
        logic [6:0]        opcode;
    } de_bundle_t;

    // Every field zero: no write, no store, no branch/jump, specifiers that
    // never match a forwarding compare, and an opcode that is not a load.
    localparam de_bundle_t DE_BUBBLE = '0;

    // Replace the control group with bubble values while keeping the data
    // and specifier fields of the bundle.
    function automatic de_bundle_t squash_ctrl(input de_bundle_t b);
        de_bundle_t r;
        r            = b;
        r.RegWrite   = DE_BUBBLE.RegWrite;
        r.ImmSrc     = DE_BUBBLE.ImmSrc;
        r.ResultSrc  = DE_BUBBLE.ResultSrc;
        r.ALUControl = DE_BUBBLE.ALUControl;
        r.ALUSrc     = DE_BUBBLE.ALUSrc;
        r.MemWrite   = DE_BUBBLE.MemWrite;
        r.Branch     = DE_BUBBLE.Branch;
        r.Jump       = DE_BUBBLE.Jump;
        r.opcode     = DE_BUBBLE.opcode;
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Event counter that increments by one on each cycle with inc high and
//   sticks at all-ones instead of wrapping.
//   Ports:
//     clk   - clock
//     rst   - synchronous active-high clear
//     inc   - count this cycle
//     count - current value
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_reg_de.sv
// ---------------------------------------------------------------------------
// pipe_reg_de
//   Decode-to-execute pipeline register. Captures the decoded bundle and
//   presents it to execute one cycle later, with stall (hold) and flush
//   (bubble) support and a valid bit that marks real instructions.
//   Update priority: rst > FlushE > StallE > load.
//   Ports:
//     clk, rst   - clock, synchronous active-high reset
//     BundleD    - decoded bundle from decode
//     ValidD     - decode slot holds a real instruction
//     StallE     - hold current contents
//     FlushE     - load a bubble instead of BundleD
//     BundleE    - registered bundle to execute
//     ValidE     - execute slot holds a real instruction
//     BubbleE    - slot filled by flush or reset
//     BubbleCnt  - flush-bubble count   (only with DE_BUBBLE_CNT_EN)
//     StallCnt   - stall-hold count     (only with DE_BUBBLE_CNT_EN)
//   Optional feature macro: DE_BUBBLE_CNT_EN.
// ---------------------------------------------------------------------------
module pipe_reg_de
    import core_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  de_bundle_t BundleD,
    input  logic       ValidD,
    input  logic       StallE,
    input  logic       FlushE,
    output de_bundle_t BundleE,
    output logic       ValidE,
    output logic       BubbleE
`ifdef DE_BUBBLE_CNT_EN
    ,
    output logic [31:0] BubbleCnt,
    output logic [31:0] StallCnt
`endif
);

    // State width derived from the parameters; it equals $bits(de_bundle_t)
    // only when the parameters agree with the package widths, so a mismatch
    // surfaces as a width warning on the assignments below.
    localparam int BUNDLE_W = 5*DATA_WIDTH + 3*ADDR_WIDTH + 23;

    logic [BUNDLE_W-1:0] bundle_reg;
    logic                valid_reg;
    logic                bubble_reg;
    de_bundle_t          load_bundle;

    // An invalid decode slot must not cause side effects in execute, so its
    // control group is forced to bubble values; data fields still flow.
    always_comb begin
        load_bundle = BundleD;
        if (!ValidD) begin
            load_bundle = squash_ctrl(BundleD);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            bundle_reg <= DE_BUBBLE;
            valid_reg  <= 1'b0;
            bubble_reg <= 1'b1;
        end else if (!StallE) begin
            bundle_reg <= load_bundle;
            valid_reg  <= ValidD;
            bubble_reg <= 1'b0;
        end
    end

    assign BundleE = bundle_reg;
    assign ValidE  = valid_reg;
    assign BubbleE = bubble_reg;

`ifdef DE_BUBBLE_CNT_EN
    // Index 0: flush loaded a bubble. Index 1: stall hold taken.
    // Reset edges are excluded from both.
    logic [1:0]  cnt_inc;
    logic [31:0] cnt_val [2];

    assign cnt_inc[0] = FlushE && !rst;
    assign cnt_inc[1] = StallE && !FlushE && !rst;

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        sat_counter #(
            .WIDTH (32)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (cnt_inc[gi]),
            .count (cnt_val[gi])
        );
    end

    assign BubbleCnt = cnt_val[0];
    assign StallCnt  = cnt_val[1];
`endif

endmodule
